// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, functs and ALU codes.
package ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECUTE = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB   = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH  = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDIEX  = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIWB  = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP    = 4'd11;
  localparam logic [STATE_W-1:0] S_BNE     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // Codes kept at the widest (4-bit) form; narrow builds truncate the zero MSB.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

endpackage

// File: rtl/alu_decode_p.sv
// ALU control decode: fixed ADD/SUB modes or the R-type funct field.
module alu_decode_p
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 0,
  localparam int unsigned ALUC_W = 3 + EXT_OPS
) (
  input  logic [5:0]        funct,
  input  aluop_e            aluop,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              funct_valid
);

  logic [3:0] fcode;

  // Funct lookup; XOR/NOR only exist in the extended build.
  always_comb begin
    fcode       = ALU_ADD;
    funct_valid = 1'b0;
    case (funct)
      F_ADD: begin fcode = ALU_ADD; funct_valid = 1'b1; end
      F_SUB: begin fcode = ALU_SUB; funct_valid = 1'b1; end
      F_AND: begin fcode = ALU_AND; funct_valid = 1'b1; end
      F_OR:  begin fcode = ALU_OR;  funct_valid = 1'b1; end
      F_SLT: begin fcode = ALU_SLT; funct_valid = 1'b1; end
      F_XOR: if (EXT_OPS != 0) begin fcode = ALU_XOR; funct_valid = 1'b1; end
      F_NOR: if (EXT_OPS != 0) begin fcode = ALU_NOR; funct_valid = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_ADD: alucontrol = ALUC_W'(ALU_ADD);
      ALUOP_SUB: alucontrol = ALUC_W'(ALU_SUB);
      default:   alucontrol = ALUC_W'(fcode);
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 0,
  localparam int unsigned ALUC_W = 3 + EXT_OPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              memready,
  output logic              pcen,
  output logic              memwrite,
  output logic              irwrite,
  output logic              regwrite,
  output logic              iord,
  output logic              alusrca,
  output logic              regdst,
  output logic              memtoreg,
  output logic              illegal,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic [3:0]        state_o
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  aluop_e             aluop;
  logic               funct_valid;
  logic               pcwrite;
  logic               branch_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next state and per-state control decode.
  always_comb begin
    state_nxt   = S_FETCH;
    pcwrite     = 1'b0;
    branch_take = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    illegal     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = memready;
        pcwrite   = memready;
        state_nxt = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) state_nxt = S_EXECUTE;
            else             illegal   = 1'b1;
          end
          OP_BEQ:  state_nxt = S_BRANCH;
          OP_ADDI: state_nxt = S_ADDIEX;
          OP_J:    state_nxt = S_JUMP;
          OP_BNE: begin
            if (EXT_OPS != 0) state_nxt = S_BNE;
            else              illegal   = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        state_nxt = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = memready ? S_FETCH : S_MEMWR;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = 2'b01;
        branch_take = zero;
      end
      S_BNE: begin
        if (EXT_OPS != 0) begin
          alusrca     = 1'b1;
          aluop       = ALUOP_SUB;
          pcsrc       = 2'b01;
          branch_take = ~zero;
        end
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen    = pcwrite | branch_take;
  assign state_o = state;

  alu_decode_p #(
    .EXT_OPS(EXT_OPS)
  ) u_alu_decode (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .funct_valid(funct_valid)
  );

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter EXT_OPS, default 0, meaning: 1 enables XOR/NOR R-type functs and BNE.
REQ-002 SHALL have localparam ALUC_W = 3 + EXT_OPS, the alucontrol width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op  in  6  instruction-register opcode; funct  in  6  instruction-register funct field.
REQ-006 zero  in  1  ALU zero flag; memready  in  1  memory access completes this cycle.
REQ-007 Outputs, 1 bit each: pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal.
REQ-008 Outputs: alusrcb (2 bits), pcsrc (2 bits), alucontrol (ALUC_W bits), state_o (4 bits, current state for debug).

Function
REQ-009 SHALL be a Moore FSM; outputs SHALL decode from the state register, plus memready, zero, op and funct where stated.
REQ-010 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12 (BNE only when EXT_OPS=1).
REQ-011 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=00.
REQ-012 FETCH: irwrite=pcwrite=memready; stay in FETCH while memready=0, go to DECODE when memready=1.
REQ-013 DECODE: alusrca=0, alusrcb=11, alucontrol=ADD. Next state by op: 100011/101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; 000101->BNE (EXT_OPS=1).
REQ-014 Unsupported op in DECODE SHALL assert illegal=1 for that cycle and go to FETCH.
REQ-015 R-type with unsupported funct SHALL assert illegal=1 in DECODE and go to FETCH; regwrite SHALL never assert for it.
REQ-016 MEMADR: alusrca=1, alusrcb=10, ADD; next MEMRD for op 100011, MEMWR for op 101011.
REQ-017 MEMRD: iord=1; hold until memready=1, then MEMWB.
REQ-018 MEMWR: iord=1, memwrite=1 held every cycle; hold until memready=1, then FETCH.
REQ-019 MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
REQ-020 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct; next ALUWB. ALUWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
REQ-021 funct map: 100000 ADD=010, 100010 SUB=110, 100100 AND=000, 100101 OR=001, 101010 SLT=111.
REQ-022 With EXT_OPS=1, codes SHALL widen to 4 bits (MSB 0 for the base ops); 100110 XOR=0100 and 100111 NOR=0101 SHALL be added.
REQ-023 BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero; next FETCH. BNE: the same with pcen=~zero.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, ADD; next ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-026 pcen SHALL equal pcwrite OR the branch condition; every other write enable SHALL be 0 in any state not listed for it.
REQ-027 Latencies: R-type/addi 4 cycles, sw 4, lw 5, beq/bne/j 3, each plus memready wait cycles.

Reset
REQ-028 reset=1 SHALL force state to FETCH immediately, with no clock edge, including mid-instruction (e.g. in MEMWR).
REQ-029 Output values while reset=1 and memready=0: state_o=0, memwrite=regwrite=irwrite=pcen=illegal=0, alusrcb=01, alucontrol=ADD, pcsrc=00, iord=0.
REQ-030 Release of reset SHALL begin a normal FETCH on the next edge.

Structure
REQ-031 Package ctrl_pkg SHALL hold the state encodings, opcode and funct constants, and alucontrol codes.
REQ-032 Function-field decode SHALL be sub-module alu_decode_p (parameter EXT_OPS; inputs funct and a mode select; outputs alucontrol and funct_valid).

Verification
REQ-033 Reset held with memready=0, then released, memready=1 on the 3rd cycle -> FETCH held 2 cycles; irwrite=pcen=1 only in cycle 3; next state DECODE.
REQ-034 op=100011 with memready=1 always -> states 0,1,2,3,4; regwrite=memtoreg=1 in state 4 only. Repeat with memready low for 3 cycles in MEMRD -> MEMRD held 3 extra cycles.
REQ-035 op=000000, funct=101010 -> alucontrol=111 in EXECUTE; regwrite=regdst=1 in ALUWB. funct=111111 -> illegal=1 in DECODE, then FETCH, no regwrite.
REQ-036 op=000100: zero=1 gives pcen=1, pcsrc=01 in BRANCH; zero=0 gives pcen=0.
REQ-037 EXT_OPS=1: op=000101 with zero=0 gives pcen=1 in BNE; funct=100111 gives alucontrol=0101.
REQ-038 reset asserted mid-MEMWR -> memwrite=0 and state_o=0 before the next clock edge.
